// File: rtl/psa_simd_unit_if.sv
// psa_simd_unit_if: operand/result handshake bundle for the partitioned saturating SIMD unit.
// Carries the op select only when PSA_SIMD_SUB_EN is defined.
interface psa_simd_unit_if #(parameter int DATA_W = 16);
  localparam int NLANE4 = DATA_W / 4;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [1:0]        mode;
`ifdef PSA_SIMD_SUB_EN
  logic              op;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sum;
  logic [NLANE4-1:0] ovf;
  logic              sticky_err;
  logic              clr_err;
  modport master (
    output in_valid, a, b, mode,
`ifdef PSA_SIMD_SUB_EN
    output op,
`endif
    output out_ready, clr_err,
    input  in_ready, out_valid, sum, ovf, sticky_err
  );
  modport slave (
    input  in_valid, a, b, mode,
`ifdef PSA_SIMD_SUB_EN
    input  op,
`endif
    input  out_ready, clr_err,
    output in_ready, out_valid, sum, ovf, sticky_err
  );
endinterface

// File: rtl/psa_simd_unit.sv
// psa_simd_unit: two-stage valid/ready partitioned signed saturating adder (4/8/16-bit lanes).
// Defining PSA_SIMD_SUB_EN adds the op input selecting per-lane a - b.
module psa_simd_unit #(
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst_n,
  psa_simd_unit_if.slave s
);
  localparam int NLANE4 = DATA_W / 4;
  logic                   s1_valid, out_valid, sticky, s1_ready, s2_ready, sub;
  logic [DATA_W-1:0]      s1_a, s1_b, sum_q;
  logic [1:0]             s1_mode, sel;
  logic [NLANE4-1:0]      ovf_q;
  logic [2:0][DATA_W-1:0] res;
  logic [2:0][NLANE4-1:0] ov;
`ifdef PSA_SIMD_SUB_EN
  logic s1_op;
  assign sub = s1_op;
`else
  assign sub = 1'b0;
`endif
  assign s2_ready = !out_valid || s.out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign s.in_ready = s1_ready;
  assign s.out_valid = out_valid;
  assign s.sum = sum_q;
  assign s.ovf = ovf_q;
  assign s.sticky_err = sticky;
  always_ff @(posedge clk)
    if (s.in_valid && s1_ready) begin
      s1_a <= s.a;
      s1_b <= s.b;
      s1_mode <= s.mode;
`ifdef PSA_SIMD_SUB_EN
      s1_op <= s.op;
`endif
    end
  // Every lane width is evaluated in parallel; S2 picks one by mode. Subtract
  // inverts b with carry-in 1, so the add overflow rule on the inverted b covers both.
  for (genvar k = 0; k < 3; k++) begin : g_w
    localparam int L = 4 << k;
    localparam int G = L / 4;
    for (genvar i = 0; i < DATA_W / L; i++) begin : g_l
      logic [L-1:0] x, y, r;
      logic         o;
      assign x = s1_a[L*i +: L];
      assign y = s1_b[L*i +: L] ^ {L{sub}};
      assign r = x + y + L'(sub);
      assign o = (x[L-1] == y[L-1]) && (r[L-1] != x[L-1]);
      assign res[k][L*i +: L] = o ? {x[L-1], {(L-1){~x[L-1]}}} : r;
      assign ov[k][G*i +: G] = G'(o) << (G - 1);
    end
  end
  assign sel = s1_mode == 2'b01 ? 2'd1 : s1_mode == 2'b10 ? 2'd2 : 2'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      sum_q <= '0;
      ovf_q <= '0;
      sticky <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= s.in_valid;
      if (s2_ready) out_valid <= s1_valid;
      if (s2_ready && s1_valid) begin
        sum_q <= res[sel];
        ovf_q <= ov[sel];
      end
      sticky <= (out_valid && s.out_ready && |ovf_q) || (sticky && !s.clr_err);
    end
endmodule

// File: tb/tb_psa_simd_unit.sv
// tb_psa_simd_unit: directed vector table, hand-written corner sequences and a
// randomized scoreboard run against an integer-arithmetic lane model.
module tb_psa_simd_unit;
  localparam int DW = 16;
  localparam int NL = DW / 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  psa_simd_unit_if #(.DATA_W(DW)) s ();
  psa_simd_unit #(.DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .s(s));

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] a, b, es;
    logic [NL-1:0] eo;
  } vec_t;
  typedef struct {
    logic [DW-1:0] es;
    logic [NL-1:0] eo;
    int            acc;
  } exp_t;
  vec_t vt[9];
  exp_t q[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [1:0] m, input logic op,
                                output logic [DW-1:0] rs, output logic [NL-1:0] ro);
    int l, x, y, r, hi, lo, msk;
    l = m == 2'b01 ? 8 : m == 2'b10 ? 16 : 4;
    hi = (1 << (l - 1)) - 1;
    lo = -(1 << (l - 1));
    msk = (1 << l) - 1;
    rs = '0;
    ro = '0;
    for (int i = 0; i < DW / l; i++) begin
      x = (int'(a) >> (i * l)) & msk;
      y = (int'(b) >> (i * l)) & msk;
      if (x > hi) x -= (1 << l);
      if (y > hi) y -= (1 << l);
      r = op ? x - y : x + y;
      if (r > hi || r < lo) ro[i * l / 4 + l / 4 - 1] = 1'b1;
      r = r > hi ? hi : r < lo ? lo : r;
      rs = rs | (DW'(r & msk) << (i * l));
    end
  endfunction

  task automatic idle;
    s.in_valid = 1'b0;
    s.a = '0;
    s.b = '0;
    s.mode = 2'b00;
`ifdef PSA_SIMD_SUB_EN
    s.op = 1'b0;
`endif
  endtask

  task automatic drive(input logic [1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    s.in_valid = 1'b1;
    s.mode = m;
    s.a = a;
    s.b = b;
  endtask

  initial begin
    logic [DW-1:0] ms;
    logic [NL-1:0] mo;
    logic          opv, st, fire, acc;
    exp_t          e;
    vt[0] = '{2'b00, 16'h1234, 16'h1111, 16'h2345, 4'h0};
    vt[1] = '{2'b00, 16'h7777, 16'h1111, 16'h7777, 4'hF};
    vt[2] = '{2'b00, 16'h8888, 16'h8888, 16'h8888, 4'hF};
    vt[3] = '{2'b01, 16'h7F80, 16'h0180, 16'h7F80, 4'hA};
    vt[4] = '{2'b10, 16'h8000, 16'hFFFF, 16'h8000, 4'h8};
    vt[5] = '{2'b10, 16'h7FFE, 16'h0001, 16'h7FFF, 4'h0};
    vt[6] = '{2'b11, 16'h7777, 16'h1111, 16'h7777, 4'hF};
    vt[7] = '{2'b01, 16'h1234, 16'h1111, 16'h2345, 4'h0};
    vt[8] = '{2'b00, 16'h9876, 16'h8765, 16'h8F77, 4'hB};
    idle();
    s.out_ready = 1'b1;
    s.clr_err = 1'b0;
    #12;
    chk("rst_out_valid", 32'(s.out_valid), 0);
    chk("rst_sum", 32'(s.sum), 0);
    chk("rst_ovf", 32'(s.ovf), 0);
    chk("rst_sticky", 32'(s.sticky_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      tick();
      drive(vt[v].mode, vt[v].a, vt[v].b);
      s.clr_err = 1'b1;
      tick();
      idle();
      s.clr_err = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_lat1_valid", v), 32'(s.out_valid), 0);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_valid", v), 32'(s.out_valid), 1);
      chk($sformatf("v%0d_sum", v), 32'(s.sum), 32'(vt[v].es));
      chk($sformatf("v%0d_ovf", v), 32'(s.ovf), 32'(vt[v].eo));
      chk($sformatf("v%0d_sticky_pre", v), 32'(s.sticky_err), 0);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_sticky", v), 32'(s.sticky_err), 32'(vt[v].eo != 0));
      chk($sformatf("v%0d_drain", v), 32'(s.out_valid), 0);
    end

    tick();
    s.out_ready = 1'b0;
    drive(2'b00, 16'h1111, 16'h1111);
    @(negedge clk);
    chk("bp_rdy0", 32'(s.in_ready), 1);
    tick();
    drive(2'b00, 16'h0101, 16'h0202);
    @(negedge clk);
    chk("bp_rdy1", 32'(s.in_ready), 1);
    tick();
    drive(2'b00, 16'h1234, 16'h0000);
    @(negedge clk);
    chk("bp_rdy2", 32'(s.in_ready), 0);
    chk("bp_valid", 32'(s.out_valid), 1);
    chk("bp_sum", 32'(s.sum), 32'h2222);
    tick();
    @(negedge clk);
    chk("bp_hold_rdy", 32'(s.in_ready), 0);
    chk("bp_hold_valid", 32'(s.out_valid), 1);
    chk("bp_hold_sum", 32'(s.sum), 32'h2222);
    chk("bp_hold_ovf", 32'(s.ovf), 0);
    s.out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", 32'(s.in_ready), 1);
    tick();
    idle();
    @(negedge clk);
    chk("bp_o1_valid", 32'(s.out_valid), 1);
    chk("bp_o1_sum", 32'(s.sum), 32'h0303);
    tick();
    @(negedge clk);
    chk("bp_o2_valid", 32'(s.out_valid), 1);
    chk("bp_o2_sum", 32'(s.sum), 32'h1234);
    tick();
    @(negedge clk);
    chk("bp_empty", 32'(s.out_valid), 0);

    tick();
    s.clr_err = 1'b1;
    drive(2'b00, 16'h7777, 16'h1111);
    tick();
    s.clr_err = 1'b0;
    idle();
    tick();
    @(negedge clk);
    chk("race_valid", 32'(s.out_valid), 1);
    chk("race_pre", 32'(s.sticky_err), 0);
    s.clr_err = 1'b1;
    tick();
    @(negedge clk);
    chk("race_set_wins", 32'(s.sticky_err), 1);
    tick();
    s.clr_err = 1'b0;
    @(negedge clk);
    chk("race_cleared", 32'(s.sticky_err), 0);

    tick();
    s.out_ready = 1'b0;
    drive(2'b00, 16'h7777, 16'h1111);
    tick();
    drive(2'b01, 16'h1234, 16'h1111);
    tick();
    idle();
    @(negedge clk);
    chk("rstf_inflight", 32'(s.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rstf_valid", 32'(s.out_valid), 0);
    chk("rstf_sum", 32'(s.sum), 0);
    chk("rstf_ovf", 32'(s.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstf_in_ready", 32'(s.in_ready), 1);
    s.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rstf_stale%0d", i), 32'(s.out_valid), 0);
    end

    st = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      s.in_valid = $urandom_range(3) != 0;
      s.mode = 2'($urandom_range(3));
      s.a = DW'($urandom);
      s.b = DW'($urandom);
      if ($urandom_range(3) == 0) s.b = s.a;
      s.out_ready = $urandom_range(2) != 0;
      s.clr_err = $urandom_range(7) == 0;
      opv = 1'b0;
`ifdef PSA_SIMD_SUB_EN
      s.op = 1'($urandom);
      opv = s.op;
`endif
      @(negedge clk);
      chk("rnd_in_ready", 32'(s.in_ready), 32'(q.size() < 2 || s.out_ready));
      chk("rnd_out_valid", 32'(s.out_valid), 32'(q.size() > 0 && cyc >= q[0].acc + 1));
      chk("rnd_sticky", 32'(s.sticky_err), 32'(st));
      fire = 1'b0;
      if (s.out_valid && q.size() > 0) begin
        chk("rnd_sum", 32'(s.sum), 32'(q[0].es));
        chk("rnd_ovf", 32'(s.ovf), 32'(q[0].eo));
        fire = s.out_ready;
      end
      acc = s.in_valid && s.in_ready;
      st = (fire && q[0].eo != 0) || (st && !s.clr_err);
      if (fire) void'(q.pop_front());
      if (acc) begin
        model(s.a, s.b, s.mode, opv, ms, mo);
        e.es = ms;
        e.eo = mo;
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
    tick();
    idle();
    s.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (s.out_valid && q.size() > 0) begin
        chk("tail_sum", 32'(s.sum), 32'(q[0].es));
        void'(q.pop_front());
      end
      tick();
    end
    chk("tail_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/psa_simd_unit.md
Name: psa_simd_unit

Overview:
Parametrised, pipelined successor to the 16-bit partitioned saturating adder. It adds two DATA_W-bit words as independent signed lanes, with the lane width selected per transaction (4, 8 or 16 bits), and saturates each lane on overflow. It sits in the EX stage beside the ALU. A two-stage valid/ready pipeline lets it stall under downstream backpressure, and a sticky overflow status register records any lane overflow.

Parameters:
DATA_W, 16, operand width; must be a multiple of 16.
NLANE4, DATA_W/4, number of nibble lanes; derived, not overridable.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand transaction valid
in_ready  out  1  unit can accept an operand transaction this cycle
a  in  DATA_W  operand A
b  in  DATA_W  operand B
mode  in  2  lane width: 00 = 4-bit, 01 = 8-bit, 10 = 16-bit, 11 = reserved (treated as 00)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
sum  out  DATA_W  per-lane saturated sum
ovf  out  NLANE4  per-lane overflow mask
sticky_err  out  1  set by any accepted result with ovf != 0
clr_err  in  1  synchronous clear of sticky_err

Behaviour:
- Reset (asynchronous, rst_n = 0): S1/S2 valid bits = 0, out_valid = 0, sum = 0, ovf = 0, sticky_err = 0. Internal data registers are don't-care.
- Reset asserted mid-operation discards all in-flight transactions immediately. No output is produced for them after reset releases.
- Stage S1: registers a, b and mode when in_valid & in_ready.
- Stage S2: computes the lane sums from the S1 registers, then registers sum, ovf and out_valid.
- Latency: 2 cycles from input acceptance to out_valid when the pipeline is not stalled. Throughput: 1 transaction per cycle.
- Handshake chaining: s2_ready = !out_valid | out_ready; s1_ready = !s1_valid | s2_ready; in_ready = s1_ready.
  - in_ready is combinational from out_ready.
  - At most 2 transactions are in flight. No loss or duplication; order is preserved.
- Output stability: sum, ovf and out_valid hold stable while out_valid & !out_ready.
- Lane arithmetic:
  - Each lane of width L computes a signed (L+1)-bit sum of the corresponding A and B slices. No carry crosses lane boundaries.
  - Overflow occurs when both operand sign bits are equal and the result sign differs.
  - Positive overflow gives 0 followed by L-1 ones; negative overflow gives 1 followed by L-1 zeros.
- ovf mapping: the bit at the lane's most-significant nibble index is set on overflow; the other nibble bits of that lane are 0.
- sticky_err:
  - Set on the cycle a result with ovf != 0 is accepted (out_valid & out_ready).
  - Cleared by clr_err.
  - If set and clear occur in the same cycle, set wins.
- mode = 11 behaves exactly as mode = 00.

Optional Feature:
Macro PSA_SIMD_SUB_EN.
- Defined:
  - Adds input port op (1 bit, registered in S1 alongside mode).
  - op = 1 computes a - b per lane: b is inverted with carry-in 1 per lane.
  - Subtract overflow occurs when the sign of a differs from the sign of b and the result sign differs from the sign of a. Saturation rules are the same as for add.
- Not defined: port op is absent and the unit adds only. Behaviour is otherwise identical.

Test Plan:
- DATA_W=16, mode 00, a=0x1234, b=0x1111 -> after 2 cycles: sum=0x2345, ovf=0x0, sticky_err stays 0.
- mode 00, a=0x7777, b=0x1111 -> sum=0x7777, ovf=0xF, sticky_err=1 the cycle after acceptance. Also mode 00, a=0x8888, b=0x8888 -> sum=0x8888, ovf=0xF.
- mode 01, a=0x7F80, b=0x0180 -> sum=0x7F80, ovf=0xA. Mode 10, a=0x8000, b=0xFFFF -> sum=0x8000, ovf=0x8. Mode 10, a=0x7FFE, b=0x0001 -> sum=0x7FFF, ovf=0x0.
- Backpressure:
  - Stimulus: out_ready=0 while in_valid=1 with 3 distinct transactions.
  - Required: in_ready drops after 2 are accepted; outputs hold stable.
  - On release of out_ready, results emerge in order, one per cycle, with the third accepted.
- sticky_err race: clr_err=1 in the same cycle an overflowing result is accepted -> sticky_err=1. clr_err alone next cycle -> sticky_err=0.
- rst_n pulsed low with 2 transactions in flight -> out_valid=0, sum=0, ovf=0 immediately. After release, no stale results appear, and in_ready=1 the first cycle out of reset.
